game_scheduler: RTL
===================

GAME_SCHEDULER -- requirements
Module: game_scheduler

Interface
REQ-001 SHALL have parameter MAX_HEALTH, default 5: player health loaded on game start (range 1..7).
REQ-002 SHALL have parameter HIT_TICKS, default 3: ticks of invulnerability after each granted attack.
REQ-003 SHALL have parameter WIN_KILLS, default 9: kills required to win (range 1..15).
REQ-004 SHALL have clk, input, 1: the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have tick, input, 1: one-clk-wide pulse at about 3 Hz, synchronous to clk.
REQ-007 SHALL have start, input, 1: one-clk-wide pulse; starts or restarts the game.
REQ-008 SHALL have attack_req, input, 3: per-lane attack pulses; bit0 forward, bit1 left, bit2 right.
REQ-009 SHALL have kill, input, 3: per-lane enemy-defeated pulses; same bit order as attack_req.
REQ-010 SHALL have game_state, output, 3: IDLE=001, RUN=010, HIT=011, OVER=100, WIN=101.
REQ-011 SHALL have attack_grant, output, 3: one-hot, one-clk pulse marking the lane whose attack landed.
REQ-012 SHALL have player_health, output, 3: remaining health.
REQ-013 SHALL have kill_count, output, 4: kills accumulated in the current game.
REQ-014 SHALL have enemy_enable, output, 1: high only in RUN or HIT; gates the enemy spawn logic.

Function
REQ-015 IDLE: on start, SHALL go to RUN and load player_health=MAX_HEALTH, kill_count=0, pending=0.
REQ-016 Pending register, 3 bits: an attack_req bit sets its pending bit in RUN/HIT only; requests are ignored in IDLE, OVER and WIN.
REQ-017 A pending bit SHALL clear when its lane is granted; if a request and the grant for the same lane fall in one cycle, the bit stays set.
REQ-018 Grant condition: state RUN, tick=1 and pending!=0 sampled at an edge; attack_grant SHALL assert at that edge for exactly one cycle. At most one grant per tick.
REQ-019 Arbitration SHALL be round-robin from pointer ptr (0..2); search order is ptr, ptr+1, ptr+2 mod 3; after a grant to lane g, ptr becomes (g+1) mod 3.
REQ-020 On the grant edge, player_health SHALL decrement by 1 and the state SHALL go to HIT with hit counter = HIT_TICKS.
REQ-021 If that decrement reaches 0, the state SHALL go to OVER instead of HIT.
REQ-022 HIT: each tick decrements the hit counter; on the tick that reaches 0 the state returns to RUN, and no grant occurs on that tick. Pending bits are retained during HIT.
REQ-023 kill_count SHALL add the popcount of kill in RUN/HIT, saturating at 15. Kills in IDLE, OVER and WIN are ignored.
REQ-024 When kill_count would reach >= WIN_KILLS, the state SHALL go to WIN.
REQ-025 If a WIN condition and health reaching 0 occur on the same edge, the state SHALL go to OVER.
REQ-026 OVER/WIN SHALL hold all outputs static, with pending cleared, until start, which re-enters RUN as in REQ-015.
REQ-027 start SHALL be ignored in RUN and HIT.
REQ-028 player_health SHALL never underflow below 0.

Reset
REQ-029 While rst_n=0, outputs SHALL be: game_state=IDLE, attack_grant=000, player_health=MAX_HEALTH, kill_count=0, enemy_enable=0; internal state: ptr=0, pending=000, hit counter=0.
REQ-030 Reset asserted mid-HIT or mid-grant SHALL abort immediately with no residual grant pulse after release.
REQ-031 The first edge after rst_n rises SHALL behave as IDLE.

Structure
REQ-032 A shared package game_pkg SHALL hold the state encodings, lane indices (FWD=0, LEFT=1, RIGHT=2), and the camera/fire encodings used elsewhere (forward 001, left 011, right 110, firing 010).
REQ-033 A combinational sub-module rr_arbiter3 SHALL take (pending, ptr) and return (grant_onehot, grant_idx); the FSM, counters and ptr register stay in game_scheduler.

Verification
REQ-034 Reset, start, then attack_req=001 and a tick -> attack_grant=001 for one cycle, health 5->4, state HIT; after 3 ticks, RUN.
REQ-035 In RUN with pending=111 and ptr=0, across 3 separate RUN grant ticks -> grants 001, 010, 100 in order; ptr ends at 0.
REQ-036 Five grants with HIT_TICKS respected -> health 0, state OVER, enemy_enable=0; further attack_req produces no grant; start -> RUN with health 5.
REQ-037 kill=111 three times in RUN -> kill_count=9, state WIN; extra kill pulses leave kill_count=9.
REQ-038 health=1 and kill_count=8; on one edge, grant and kill=001 together -> state OVER (REQ-025).
REQ-039 Assert rst_n=0 during HIT with pending=110 -> all reset values next cycle; after release, no grant until start is given and a tick occurs.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings and helpers for the game scheduler
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_HIT  = 3'b011,
    S_OVER = 3'b100,
    S_WIN  = 3'b101
  } game_state_e;

  localparam logic [1:0] LANE_FWD   = 2'd0;
  localparam logic [1:0] LANE_LEFT  = 2'd1;
  localparam logic [1:0] LANE_RIGHT = 2'd2;

  // Camera/fire indicator codes shared with the display side
  localparam logic [2:0] CAM_FWD   = 3'b001;
  localparam logic [2:0] CAM_LEFT  = 3'b011;
  localparam logic [2:0] CAM_RIGHT = 3'b110;
  localparam logic [2:0] CAM_FIRE  = 3'b010;

  function automatic logic [1:0] next_lane(input logic [1:0] lane);
    return (lane >= LANE_RIGHT) ? LANE_FWD : lane + 2'd1;
  endfunction

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// rtl/rr_arbiter3.sv - combinational three-lane round-robin arbiter
module rr_arbiter3
  import game_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] ptr,
  output logic [2:0] grant_onehot,
  output logic [1:0] grant_idx
);

  logic [1:0] l0;
  logic [1:0] l1;
  logic [1:0] l2;

  // An out-of-range pointer is treated as lane 0 so the search order stays valid
  assign l0 = (ptr > LANE_RIGHT) ? LANE_FWD : ptr;
  assign l1 = next_lane(l0);
  assign l2 = next_lane(l1);

  always_comb begin
    grant_onehot = 3'b000;
    grant_idx    = LANE_FWD;
    if (pending[l0]) begin
      grant_onehot[l0] = 1'b1;
      grant_idx        = l0;
    end else if (pending[l1]) begin
      grant_onehot[l1] = 1'b1;
      grant_idx        = l1;
    end else if (pending[l2]) begin
      grant_onehot[l2] = 1'b1;
      grant_idx        = l2;
    end
  end

endmodule

// File: rtl/game_scheduler.sv
// rtl/game_scheduler.sv - game FSM: attack arbitration, health, kills, win/lose
module game_scheduler
  import game_pkg::*;
#(
  parameter int MAX_HEALTH = 5,
  parameter int HIT_TICKS  = 3,
  parameter int WIN_KILLS  = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic [2:0] attack_req,
  input  logic [2:0] kill,
  output logic [2:0] game_state,
  output logic [2:0] attack_grant,
  output logic [2:0] player_health,
  output logic [3:0] kill_count,
  output logic       enemy_enable
);

  game_state_e state;
  logic [2:0]  pending;
  logic [1:0]  ptr;
  logic [3:0]  hit_cnt;

  logic [2:0]  arb_onehot;
  logic [1:0]  arb_idx;
  logic        grant_fire;
  logic [2:0]  grant_mask;
  logic [2:0]  health_dec;
  logic [4:0]  kill_sum;
  logic [3:0]  kill_sat;
  logic        win_hit;

  rr_arbiter3 u_arb (
    .pending      (pending),
    .ptr          (ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx)
  );

  assign game_state = state;
  assign grant_fire = (state == S_RUN) && tick && (pending != 3'b000);
  assign grant_mask = grant_fire ? arb_onehot : 3'b000;
  assign health_dec = (player_health == 3'd0) ? 3'd0 : player_health - 3'd1;
  assign kill_sum   = {1'b0, kill_count} + {3'b000, popcount3(kill)};
  assign kill_sat   = (kill_sum > 5'd15) ? 4'd15 : kill_sum[3:0];
  assign win_hit    = (kill_sat >= 4'(WIN_KILLS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      attack_grant  <= 3'b000;
      player_health <= 3'(MAX_HEALTH);
      kill_count    <= 4'd0;
      enemy_enable  <= 1'b0;
      ptr           <= LANE_FWD;
      pending       <= 3'b000;
      hit_cnt       <= 4'd0;
    end else begin
      attack_grant <= 3'b000;
      case (state)
        S_IDLE, S_OVER, S_WIN: begin
          pending <= 3'b000;
          if (start) begin
            state         <= S_RUN;
            player_health <= 3'(MAX_HEALTH);
            kill_count    <= 4'd0;
            hit_cnt       <= 4'd0;
            enemy_enable  <= 1'b1;
          end
        end

        S_RUN, S_HIT: begin
          kill_count <= kill_sat;
          // A same-cycle request re-arms the lane that is being granted
          pending    <= (pending & ~grant_mask) | attack_req;
          if (grant_fire) begin
            attack_grant  <= arb_onehot;
            ptr           <= next_lane(arb_idx);
            player_health <= health_dec;
          end

          // Losing the last health point outranks a simultaneous win
          if (grant_fire && (health_dec == 3'd0)) begin
            state        <= S_OVER;
            pending      <= 3'b000;
            enemy_enable <= 1'b0;
          end else if (win_hit) begin
            state        <= S_WIN;
            pending      <= 3'b000;
            enemy_enable <= 1'b0;
          end else if (grant_fire) begin
            state   <= S_HIT;
            hit_cnt <= 4'(HIT_TICKS);
          end else if ((state == S_HIT) && tick) begin
            if (hit_cnt <= 4'd1) begin
              state   <= S_RUN;
              hit_cnt <= 4'd0;
            end else begin
              hit_cnt <= hit_cnt - 4'd1;
            end
          end
        end

        default: begin
          state        <= S_IDLE;
          pending      <= 3'b000;
          hit_cnt      <= 4'd0;
          enemy_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
